gnr_node_lut: RTL
=================

Name: gnr_node_lut

Overview:
Generic Boolean-network node for the GNR attractor-search fabric. It replaces the fixed-equation nodes with a runtime-programmable truth table (LUT) over NUM_IN regulator inputs. It keeps two trajectory copies: s0 is the slow/tortoise copy, which updates once every SLOW_DIV start_s0 pulses, and s1 is the fast/hare copy, which updates on every start_s1 pulse. It also provides a per-node equality flag for the network-wide cycle detector and a saturating activity counter on the s1 trajectory.

Parameters:
NUM_IN, 4, number of regulator inputs; LUT depth is 2^NUM_IN (1..6 legal)
SLOW_DIV, 2, s0 update divider: s0 updates on 1 of every SLOW_DIV start_s0 pulses (>=1)
CNT_W, 16, width of the s1 toggle counter
LUT_INIT, all-zero (2^NUM_IN bits), LUT contents after reset

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  asynchronous active-low reset; asserted when 0
reset_nos  in  1  synchronous re-seed of both trajectories from init_state
init_state  in  1  seed value loaded by reset_nos
start_s0  in  1  step request for the slow copy
start_s1  in  1  step request for the fast copy
in_s0  in  NUM_IN  regulator states for the s0 trajectory, bit i = regulator i
in_s1  in  NUM_IN  regulator states for the s1 trajectory
cfg_we  in  1  LUT write strobe
cfg_lut  in  2^NUM_IN  new truth table; bit k = next state for input pattern k
s0  out  1  slow trajectory state (registered)
s1  out  1  fast trajectory state (registered)
eq  out  1  registered flag, s0 == s1
toggle_cnt  out  CNT_W  number of s1 value changes since last re-seed, saturating
lut_q  out  2^NUM_IN  current LUT contents, for readback

Behaviour:
- Async reset (rst=0) sets: s0=0, s1=0, eq=1, toggle_cnt=0, phase=0, lut_q=LUT_INIT. Outputs stay there until rst releases.
- Priority per clock: reset_nos > step updates. cfg_we is independent of the step updates.
- reset_nos=1: s0<=init_state, s1<=init_state, phase<=0, toggle_cnt<=0, eq<=1. All starts in that cycle are ignored.
- Next-state function: f(x) = lut_q[x], where x = unsigned index formed from the in bus (bit i = input i).
- s0 path: internal phase counter, width clog2(SLOW_DIV), minimum 1.
  - On start_s0 with phase==0: s0<=f(in_s0).
  - On every start_s0: phase<=(phase==SLOW_DIV-1)?0:phase+1.
  - No start_s0: hold s0 and phase.
  - SLOW_DIV=1: s0 updates on every start_s0.
  - SLOW_DIV=2 matches the legacy pass-toggle timing: the first start after re-seed updates, the second skips.
- s1 path: on start_s1, s1<=f(in_s1). When the new value differs from the current s1 and toggle_cnt < 2^CNT_W-1, toggle_cnt increments. At max it holds (no wrap).
- eq: registered every cycle from the next-state values of s0 and s1. It is valid 1 cycle after any update, with 0 extra latency relative to s0/s1.
- start_s0 and start_s1 together: both paths update independently in the same cycle.
- cfg_we=1: lut_q<=cfg_lut at the clock edge. A step in the same cycle evaluates with the OLD LUT; the new LUT is used from the next cycle. cfg_we together with reset_nos: both take effect.
- Step latency: 1 cycle, i.e. the output is valid on the edge after the start strobe.
- Async reset mid-operation: immediate clear, and the pending step is lost. On release, the first edge behaves as after power-up.
- Inputs are sampled only on the active edge. There is no combinational path from any input to any output.

Test Plan:
- Reset/defaults: hold rst=0 for 3 cycles with strobes active -> s0=s1=0, eq=1, toggle_cnt=0, lut_q=LUT_INIT. Release rst -> no change without strobes.
- OR-gate equivalence (NUM_IN=2, SLOW_DIV=2): cfg_lut=4'b1110, reset_nos with init_state=0, in_s0=in_s1=2'b01, then 4 simultaneous start pulses -> s1=1 after 1st pulse. s0=1 after the 1st pulse (phase 0) and holds through the 2nd. Repeat with in=00: s0 changes only on the 1st and 3rd pulses.
- Divider sweep: SLOW_DIV=3, alternate the LUT output between 1 and 0 -> s0 updates on start_s0 pulses #1, #4, #7; eq tracks s0==s1 one cycle after each update.
- LUT write collision: cfg_we with cfg_lut=all-ones in the same cycle as start_s1, old LUT all-zero -> s1=0 that edge. Next start_s1 -> s1=1.
- Toggle counter saturation (CNT_W=3): drive s1 to alternate on 10 consecutive start_s1 -> toggle_cnt reads 1..7 then holds 7. reset_nos -> 0.
- Priority/async: reset_nos together with start_s0/start_s1 and init_state=1 -> s0=s1=1, phase=0. Assert rst mid-stream between edges -> outputs clear before the next edge.

Source files
------------

// File: rtl/gnr_node_lut_if.sv
// Bus bundle for one GNR LUT node: step/config strobes in, trajectory state out.
interface gnr_node_lut_if #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
);
    localparam int DEPTH = 1 << NUM_IN;

    logic              reset_nos;
    logic              init_state;
    logic              start_s0;
    logic              start_s1;
    logic [NUM_IN-1:0] in_s0;
    logic [NUM_IN-1:0] in_s1;
    logic              cfg_we;
    logic [DEPTH-1:0]  cfg_lut;
    logic              s0;
    logic              s1;
    logic              eq;
    logic [CNT_W-1:0]  toggle_cnt;
    logic [DEPTH-1:0]  lut_q;

    modport master (
        output reset_nos, init_state, start_s0, start_s1,
        output in_s0, in_s1, cfg_we, cfg_lut,
        input  s0, s1, eq, toggle_cnt, lut_q
    );

    modport slave (
        input  reset_nos, init_state, start_s0, start_s1,
        input  in_s0, in_s1, cfg_we, cfg_lut,
        output s0, s1, eq, toggle_cnt, lut_q
    );
endinterface

// File: rtl/gnr_node_lut.sv
// Programmable-LUT Boolean network node with tortoise (s0) / hare (s1)
// trajectories, equality flag and saturating s1 toggle counter.
module gnr_node_lut #(
    parameter int NUM_IN   = 4,
    parameter int SLOW_DIV = 2,
    parameter int CNT_W    = 16,
    parameter logic [(1<<NUM_IN)-1:0] LUT_INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    gnr_node_lut_if.slave bus
);
    localparam int DEPTH = 1 << NUM_IN;
    localparam int PH_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] lut;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             s0_q;
    logic             s1_q;
    logic             eq_q;
    logic             s0_nx;
    logic             s1_nx;
    logic             f0;
    logic             f1;

    // Steps always read the LUT as it stood before this edge.
    assign f0 = lut[bus.in_s0];
    assign f1 = lut[bus.in_s1];

    always_comb begin
        s0_nx    = s0_q;
        s1_nx    = s1_q;
        phase_nx = phase;
        cnt_nx   = cnt;
        if (bus.reset_nos) begin
            s0_nx    = bus.init_state;
            s1_nx    = bus.init_state;
            phase_nx = '0;
            cnt_nx   = '0;
        end else begin
            if (bus.start_s0) begin
                if (phase == '0)
                    s0_nx = f0;
                phase_nx = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end
            if (bus.start_s1) begin
                s1_nx = f1;
                if ((f1 != s1_q) && (cnt != CNT_MAX))
                    cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q  <= 1'b0;
            s1_q  <= 1'b0;
            eq_q  <= 1'b1;
            phase <= '0;
            cnt   <= '0;
            lut   <= LUT_INIT;
        end else begin
            s0_q  <= s0_nx;
            s1_q  <= s1_nx;
            eq_q  <= (s0_nx == s1_nx);
            phase <= phase_nx;
            cnt   <= cnt_nx;
            if (bus.cfg_we)
                lut <= bus.cfg_lut;
        end
    end

    assign bus.s0         = s0_q;
    assign bus.s1         = s1_q;
    assign bus.eq         = eq_q;
    assign bus.toggle_cnt = cnt;
    assign bus.lut_q      = lut;
endmodule
